mpmc11_fifo_rd_sched: RTL and testbench

Read-side scheduler for the bank of per-port mpmc11 asynchronous request FIFOs, running in the memory-controller (read) clock domain.
- Watches each port FIFO's empty and rd_rst_busy flags and picks one non-empty port by round-robin with a bounded burst allowance.
- Pulses that port's rd_fifo, captures the popped mpmc11_fifoe_t entry and presents it to the controller core on a valid/ready handshake.
- Is the only agent that reads the port FIFOs.

---
 rtl/mpmc11_pkg.sv | 20 ++
 rtl/mpmc11_rr_pick.sv | 33 +++
 rtl/mpmc11_fifo_rd_sched.sv | 165 ++++++++++++++++
 tb/tb_mpmc11_fifo_rd_sched.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpmc11_pkg.sv
// Shared types for the mpmc11 port-FIFO read side.
//   mpmc11_fifoe_t         : one request entry as stored in a port FIFO.
//   mpmc11_rdsched_state_t : read-scheduler FSM states.
package mpmc11_pkg;

  typedef struct packed {
    logic [27:0] addr;
    logic [5:0]  len;
    logic        rnw;
    logic [3:0]  tag;
  } mpmc11_fifoe_t;

  typedef enum logic [1:0] {
    ARB,
    RD,
    CAP,
    OUT
  } mpmc11_rdsched_state_t;

endpackage

// File: rtl/mpmc11_rr_pick.sv
// Combinational rotating-priority picker.
//   elig  : per-port eligibility.
//   last  : most recently granted port; the scan starts at last+1.
//   found : at least one port is eligible.
//   idx   : first eligible port in the order last+1, last+2, ... (mod NPORT).
// The scan covers NPORT offsets, so `last` itself is the final candidate.
module mpmc11_rr_pick #(
  parameter int unsigned NPORT = 8
) (
  input  logic [NPORT-1:0]         elig,
  input  logic [$clog2(NPORT)-1:0] last,
  output logic                     found,
  output logic [$clog2(NPORT)-1:0] idx
);

  typedef logic [$clog2(NPORT)-1:0] idx_t;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Walk from the farthest offset down so the nearest eligible port wins.
    for (int k = int'(NPORT); k >= 1; k--) begin
      int s;
      s = int'(last) + k;
      if (s >= int'(NPORT)) s = s - int'(NPORT);
      if (elig[s]) begin
        found = 1'b1;
        idx   = idx_t'(s);
      end
    end
  end

endmodule

// File: rtl/mpmc11_fifo_rd_sched.sv
// Read-side scheduler for the per-port mpmc11 request FIFOs (read clock domain).
//   rd_clk, rst     : clock, synchronous active-high reset.
//   port_en         : per-port arbitration mask.
//   fifo_empty      : FIFO empty flags.
//   fifo_rst_busy   : FIFO rd_rst_busy flags.
//   fifo_dout       : FIFO read data (std mode, valid the cycle after rd_fifo).
//   rd_fifo         : registered one-hot FIFO read strobe.
//   req/req_valid/req_ready/req_port : captured request toward the core.
//   busy            : FSM is not in ARB.
//   abort           : one-cycle pulse when an in-flight read is dropped.
module mpmc11_fifo_rd_sched
  import mpmc11_pkg::*;
#(
  parameter int unsigned NPORT     = 8,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic                          rd_clk,
  input  logic                          rst,
  input  logic          [NPORT-1:0]     port_en,
  input  logic          [NPORT-1:0]     fifo_empty,
  input  logic          [NPORT-1:0]     fifo_rst_busy,
  input  mpmc11_fifoe_t [NPORT-1:0]     fifo_dout,
  output logic          [NPORT-1:0]     rd_fifo,
  output mpmc11_fifoe_t                 req,
  output logic                          req_valid,
  input  logic                          req_ready,
  output logic [$clog2(NPORT)-1:0]      req_port,
  output logic                          busy,
  output logic                          abort
);

  localparam int unsigned IW = $clog2(NPORT);
  localparam int unsigned CW = $clog2(BURST_MAX + 1);

  typedef logic [IW-1:0] idx_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t BurstMax = cnt_t'(BURST_MAX);
  localparam idx_t LastRst  = idx_t'(NPORT - 1);

  mpmc11_rdsched_state_t state_q, state_d;
  logic [NPORT-1:0]      rd_fifo_q, rd_fifo_d;
  mpmc11_fifoe_t         req_q, req_d;
  logic                  req_valid_q, req_valid_d;
  idx_t                  req_port_q, req_port_d;
  logic                  busy_q, busy_d;
  logic                  abort_q, abort_d;
  idx_t                  last_q, last_d;
  idx_t                  cur_q, cur_d;
  cnt_t                  burst_cnt_q, burst_cnt_d;

  logic [NPORT-1:0] elig;
  logic             pick_found;
  idx_t             pick_idx;
  logic             keep;
  logic             grant;
  idx_t             grant_idx;

  assign elig = port_en & ~fifo_empty & ~fifo_rst_busy;

  mpmc11_rr_pick #(
    .NPORT(NPORT)
  ) u_pick (
    .elig (elig),
    .last (last_q),
    .found(pick_found),
    .idx  (pick_idx)
  );

  // Stay on the last port while its burst allowance is open; a zero count means
  // the previous grant either started a new port or was aborted.
  assign keep      = (burst_cnt_q != '0) && (burst_cnt_q < BurstMax) && elig[last_q];
  assign grant     = keep | pick_found;
  assign grant_idx = keep ? last_q : pick_idx;

  always_comb begin
    state_d     = state_q;
    rd_fifo_d   = '0;
    req_d       = req_q;
    req_valid_d = req_valid_q;
    req_port_d  = req_port_q;
    abort_d     = 1'b0;
    last_d      = last_q;
    cur_d       = cur_q;
    burst_cnt_d = burst_cnt_q;

    unique case (state_q)
      ARB: begin
        if (grant) begin
          rd_fifo_d[grant_idx] = 1'b1;
          cur_d                = grant_idx;
          // An exhausted port re-granted through the wrap starts a fresh burst.
          if ((grant_idx != last_q) || (burst_cnt_q == BurstMax)) burst_cnt_d = '0;
          last_d               = grant_idx;
          state_d              = RD;
        end
      end
      RD: begin
        if (fifo_rst_busy[cur_q]) begin
          abort_d     = 1'b1;
          burst_cnt_d = '0;
          state_d     = ARB;
        end else begin
          state_d = CAP;
        end
      end
      CAP: begin
        if (fifo_rst_busy[cur_q]) begin
          abort_d     = 1'b1;
          burst_cnt_d = '0;
          state_d     = ARB;
        end else begin
          req_d       = fifo_dout[cur_q];
          req_port_d  = cur_q;
          req_valid_d = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (req_valid_q && req_ready) begin
          req_valid_d = 1'b0;
          burst_cnt_d = (burst_cnt_q >= BurstMax) ? BurstMax : burst_cnt_q + cnt_t'(1);
          state_d     = ARB;
        end
      end
      default: state_d = ARB;
    endcase

    busy_d = (state_d != ARB);
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state_q     <= ARB;
      rd_fifo_q   <= '0;
      req_q       <= '0;
      req_valid_q <= 1'b0;
      req_port_q  <= '0;
      busy_q      <= 1'b0;
      abort_q     <= 1'b0;
      last_q      <= LastRst;
      cur_q       <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_fifo_q   <= rd_fifo_d;
      req_q       <= req_d;
      req_valid_q <= req_valid_d;
      req_port_q  <= req_port_d;
      busy_q      <= busy_d;
      abort_q     <= abort_d;
      last_q      <= last_d;
      cur_q       <= cur_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign rd_fifo   = rd_fifo_q;
  assign req       = req_q;
  assign req_valid = req_valid_q;
  assign req_port  = req_port_q;
  assign busy      = busy_q;
  assign abort     = abort_q;

endmodule

// File: tb/tb_mpmc11_fifo_rd_sched.sv
// Self-checking bench for mpmc11_fifo_rd_sched with a behavioural std-mode FIFO model.
module tb_mpmc11_fifo_rd_sched;
  import mpmc11_pkg::*;

  logic                    rd_clk;
  logic                    rst;
  logic [7:0]              port_en;
  logic [7:0]              fifo_empty;
  logic [7:0]              fifo_rst_busy;
  mpmc11_fifoe_t [7:0]     fifo_dout;
  logic [7:0]              rd_fifo;
  mpmc11_fifoe_t           req;
  logic                    req_valid;
  logic                    req_ready;
  logic [2:0]              req_port;
  logic                    busy;
  logic                    abort;

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  // FIFO model storage: bench appends, model pops on rd_fifo.
  mpmc11_fifoe_t mem [8][64];
  int            wr_n [8];
  int            rd_n [8];
  logic          flush;

  mpmc11_fifo_rd_sched #(
    .NPORT    (8),
    .BURST_MAX(4)
  ) dut (
    .rd_clk       (rd_clk),
    .rst          (rst),
    .port_en      (port_en),
    .fifo_empty   (fifo_empty),
    .fifo_rst_busy(fifo_rst_busy),
    .fifo_dout    (fifo_dout),
    .rd_fifo      (rd_fifo),
    .req          (req),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_port     (req_port),
    .busy         (busy),
    .abort        (abort)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  always_comb begin
    fifo_empty = '0;
    for (int i = 0; i < 8; i++) fifo_empty[i] = (rd_n[i] == wr_n[i]);
  end

  always @(posedge rd_clk) begin
    for (int i = 0; i < 8; i++) begin
      if (flush) begin
        rd_n[i] <= wr_n[i];
      end else if (rd_fifo[i] && (rd_n[i] != wr_n[i])) begin
        fifo_dout[i] <= mem[i][rd_n[i] & 63];
        rd_n[i]      <= rd_n[i] + 1;
      end
    end
  end

  // Strobe must be one-hot and only while the FSM is busy.
  always @(negedge rd_clk) begin
    if (!rst && (($countones(rd_fifo) > 1) || ((rd_fifo != 0) && !busy))) viol++;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  function automatic mpmc11_fifoe_t mk_entry(input int p, input int n);
    mpmc11_fifoe_t e;
    e.addr = 28'(p * 4096 + n * 16 + 3);
    e.len  = 6'(n);
    e.rnw  = p[0];
    e.tag  = 4'(p);
    return e;
  endfunction

  function automatic int oh2idx(input logic [7:0] v);
    int r = 0;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge rd_clk);
  endtask

  task automatic push(input int p, input int n);
    mem[p][wr_n[p] & 63] = mk_entry(p, n);
    wr_n[p]              = wr_n[p] + 1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    flush         = 1'b1;
    port_en       = '0;
    fifo_rst_busy = '0;
    req_ready     = 1'b0;
    repeat (2) tick();
    rst   = 1'b0;
    flush = 1'b0;
  endtask

  typedef struct {
    logic [7:0] load;
    logic [7:0] en;
    logic [7:0] rbusy;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [8];
  int   ports [12];
  int   exp_order [12];
  int   n;
  int   bad;
  int   cnt;
  mpmc11_fifoe_t snap;
  logic [2:0]    snap_port;
  logic [7:0]    seen;

  initial begin
    // Arbitration from reset (last=7, burst_cnt=0), one entry per loaded port.
    vecs[0] = '{load: 8'h08, en: 8'hff, rbusy: 8'h00, exp_rd: 8'h08};
    vecs[1] = '{load: 8'h81, en: 8'hff, rbusy: 8'h00, exp_rd: 8'h01};
    vecs[2] = '{load: 8'h81, en: 8'hfe, rbusy: 8'h00, exp_rd: 8'h80};
    vecs[3] = '{load: 8'h24, en: 8'hff, rbusy: 8'h04, exp_rd: 8'h20};
    vecs[4] = '{load: 8'h00, en: 8'hff, rbusy: 8'h00, exp_rd: 8'h00};
    vecs[5] = '{load: 8'hff, en: 8'h00, rbusy: 8'h00, exp_rd: 8'h00};
    vecs[6] = '{load: 8'hc0, en: 8'hff, rbusy: 8'h00, exp_rd: 8'h40};
    vecs[7] = '{load: 8'h80, en: 8'hff, rbusy: 8'h00, exp_rd: 8'h80};
    exp_order = '{1, 1, 1, 1, 5, 5, 5, 5, 1, 1, 5, 5};

    flush = 1'b0;
    do_reset();

    // Reset state and idle with all FIFOs empty.
    chk("rst_rd_fifo", 64'(rd_fifo), 64'h0);
    chk("rst_req", 64'(req), 64'h0);
    chk("rst_req_valid", 64'(req_valid), 64'h0);
    chk("rst_req_port", 64'(req_port), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_abort", 64'(abort), 64'h0);
    port_en = 8'hff;
    seen    = '0;
    repeat (20) begin
      tick();
      seen = seen | rd_fifo;
    end
    chk("idle_rd_fifo", 64'(seen), 64'h0);

    // Single port: latency and back-to-back entries.
    do_reset();
    push(3, 100);
    push(3, 101);
    port_en   = 8'hff;
    req_ready = 1'b1;
    tick();
    chk("single_rd_n1", 64'(rd_fifo), 64'h08);
    chk("single_busy_n1", 64'(busy), 64'h1);
    tick();
    chk("single_rd_n2", 64'(rd_fifo), 64'h00);
    chk("single_valid_n2", 64'(req_valid), 64'h0);
    tick();
    chk("single_valid_n3", 64'(req_valid), 64'h1);
    chk("single_req0", 64'(req), 64'(mk_entry(3, 100)));
    chk("single_port0", 64'(req_port), 64'h3);
    tick();
    tick();
    chk("single_rd_n5", 64'(rd_fifo), 64'h08);
    tick();
    tick();
    chk("single_valid_n7", 64'(req_valid), 64'h1);
    chk("single_req1", 64'(req), 64'(mk_entry(3, 101)));

    // Table: grant choice, latency to req_valid and captured data.
    for (int vi = 0; vi < 8; vi++) begin
      do_reset();
      for (int p = 0; p < 8; p++) if (vecs[vi].load[p]) push(p, 200 + vi);
      port_en       = vecs[vi].en;
      fifo_rst_busy = vecs[vi].rbusy;
      req_ready     = 1'b1;
      tick();
      chk($sformatf("vec%0d_rd_fifo", vi), 64'(rd_fifo), 64'(vecs[vi].exp_rd));
      if (vecs[vi].exp_rd != 0) begin
        tick();
        tick();
        chk($sformatf("vec%0d_valid", vi), 64'(req_valid), 64'h1);
        chk($sformatf("vec%0d_port", vi), 64'(req_port), 64'(oh2idx(vecs[vi].exp_rd)));
        chk($sformatf("vec%0d_req", vi), 64'(req),
            64'(mk_entry(oh2idx(vecs[vi].exp_rd), 200 + vi)));
      end
      fifo_rst_busy = '0;
      repeat (4) tick();
    end

    // Burst and rotation between ports 1 and 5.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      push(1, 400 + k);
      push(5, 400 + k);
    end
    port_en   = 8'hff;
    req_ready = 1'b1;
    n         = 0;
    for (int c = 0; c < 120 && n < 12; c++) begin
      tick();
      if (req_valid && req_ready) begin
        ports[n] = int'(req_port);
        n++;
      end
    end
    chk("burst_count", 64'(n), 64'd12);
    for (int k = 0; k < n; k++) chk($sformatf("burst_grant%0d", k), 64'(ports[k]),
                                    64'(exp_order[k]));

    // Backpressure: request held stable, no new reads while stalled.
    do_reset();
    push(2, 300);
    push(4, 301);
    port_en = 8'hff;
    n       = 0;
    for (int c = 0; c < 10 && !req_valid; c++) begin
      tick();
      n++;
    end
    chk("bp_valid", 64'(req_valid), 64'h1);
    chk("bp_req", 64'(req), 64'(mk_entry(2, 300)));
    chk("bp_port", 64'(req_port), 64'h2);
    snap      = req;
    snap_port = req_port;
    bad       = 0;
    repeat (10) begin
      tick();
      if ((req != snap) || (req_port != snap_port) || !req_valid || (rd_fifo != 0) || !busy)
        bad++;
    end
    chk("bp_stable", 64'(bad), 64'h0);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("bp_drop", 64'(req_valid), 64'h0);

    // Wrap past 7 with port 0 masked, then unmask once port 7's burst is spent.
    do_reset();
    for (int k = 0; k < 6; k++) push(7, 500 + k);
    push(0, 510);
    push(0, 511);
    port_en   = 8'hfe;
    req_ready = 1'b1;
    n         = 0;
    bad       = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      tick();
      if (req_valid && req_ready) begin
        if (req_port != 3'd7) bad++;
        n++;
        if (n == 4) port_en = 8'hff;
      end
    end
    chk("wrap_count", 64'(n), 64'd4);
    chk("wrap_port7", 64'(bad), 64'h0);
    seen = '0;
    for (int c = 0; c < 4 && seen == 0; c++) begin
      tick();
      seen = rd_fifo;
    end
    chk("wrap_unmask", 64'(seen), 64'h01);

    // Burst exhaustion with a single eligible port must not stall.
    do_reset();
    for (int k = 0; k < 6; k++) push(6, 600 + k);
    port_en   = 8'hff;
    req_ready = 1'b1;
    cnt       = 0;
    repeat (40) begin
      tick();
      if (req_valid && req_ready) cnt++;
    end
    chk("exhaust_count", 64'(cnt), 64'd6);

    // Abort: rd_rst_busy asserted during CAP of a port-2 read.
    do_reset();
    push(2, 700);
    port_en   = 8'hff;
    req_ready = 1'b1;
    tick();
    chk("abort_rd", 64'(rd_fifo), 64'h04);
    tick();
    fifo_rst_busy = 8'h04;
    tick();
    chk("abort_pulse", 64'(abort), 64'h1);
    chk("abort_valid", 64'(req_valid), 64'h0);
    chk("abort_busy", 64'(busy), 64'h0);
    fifo_rst_busy = 8'h00;
    tick();
    chk("abort_clear", 64'(abort), 64'h0);
    chk("abort_valid2", 64'(req_valid), 64'h0);
    chk("abort_idle", 64'(busy), 64'h0);

    chk("strobe_onehot", 64'(viol), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
